// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - writable instruction memory with NOP fill sweep, loader port and registered fetch
module inst_mem #(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 32,
    parameter int                DEPTH  = 256,
    parameter logic [DATA_W-1:0] NOP    = 32'h0000_0013,
    localparam int               IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              inst_err_o,
    input  logic              prog_we_i,
    input  logic [IDX_W-1:0]  prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    output logic              prog_ready_o,
    output logic              busy_o
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    fill_q, fill_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                fetch_ok;
    logic                misaligned;
    logic                out_of_range;
    logic [IDX_W-1:0]    fetch_idx;
    logic [ADDR_W-1:0]   pc_upper;

    assign fetch_idx    = pc_i[IDX_W+1:2];
    assign misaligned   = |pc_i[1:0];
    assign pc_upper     = pc_i >> (IDX_W + 2);
    assign out_of_range = |pc_upper;
    assign fetch_ok     = (state_q == S_RUN) && fetch_req_i;

    // Single memory write port, shared by the fill sweep and the loader.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        mem_we    = 1'b0;
        mem_waddr = prog_addr_i;
        mem_wdata = prog_data_i;
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = fill_q;
                mem_wdata = NOP;
                fill_d    = fill_q + 1'b1;
                if (fill_q == IDX_W'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mem_we = prog_we_i;
            end
            default: begin
                state_d = S_INIT;
                fill_d  = '0;
            end
        endcase
    end

    // Write-first: a same-cycle loader write to the fetched index is bypassed.
    always_comb begin
        inst_d  = inst_q;
        valid_d = fetch_ok;
        err_d   = 1'b0;
        if (fetch_ok) begin
            if (misaligned || out_of_range) begin
                err_d  = 1'b1;
                inst_d = NOP;
            end else if (prog_we_i && (prog_addr_i == fetch_idx)) begin
                inst_d = prog_data_i;
            end else begin
                inst_d = mem[fetch_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            fill_q  <= '0;
            inst_q  <= NOP;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign inst_err_o   = err_q;
    assign busy_o       = (state_q == S_INIT);
    assign prog_ready_o = (state_q == S_RUN);

endmodule

// File: tb/tb_inst_mem.sv
// tb/tb_inst_mem.sv - self-checking bench for inst_mem: vector table, random model compare, reset corners
module tb_inst_mem;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        fetch_req_i;
    logic [31:0] pc_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_err_o;
    logic        prog_we_i;
    logic [7:0]  prog_addr_i;
    logic [31:0] prog_data_i;
    logic        prog_ready_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_inst;

    typedef struct {
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic        req;
        logic [31:0] pc;
        logic        ev;
        logic        ee;
        logic [31:0] ei;
    } vec_t;

    vec_t vecs [14];

    inst_mem dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req_i  (fetch_req_i),
        .pc_i         (pc_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .inst_err_o   (inst_err_o),
        .prog_we_i    (prog_we_i),
        .prog_addr_i  (prog_addr_i),
        .prog_data_i  (prog_data_i),
        .prog_ready_o (prog_ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_req_i = 1'b0;
        pc_i        = '0;
        prog_we_i   = 1'b0;
        prog_addr_i = '0;
        prog_data_i = '0;
    endtask

    // Counts edges until busy_o falls while poking the loader and fetch ports;
    // none of that activity may produce a valid result or land in memory.
    task automatic run_sweep(input string tag);
        int  n;
        bit  saw_valid;
        n = 0;
        saw_valid = 0;
        while (busy_o && n < 400) begin
            prog_we_i   = 1'b1;
            prog_addr_i = 8'd7;
            prog_data_i = 32'hDEAD_BEEF;
            fetch_req_i = 1'b1;
            pc_i        = 32'h1C;
            step();
            n++;
            if (inst_valid_o) saw_valid = 1;
        end
        idle_inputs();
        chk({tag, "_sweep_len"}, n, DEPTH);
        chk({tag, "_valid_in_init"}, {31'b0, saw_valid}, 32'd0);
        chk({tag, "_ready_after"}, {31'b0, prog_ready_o}, 32'd1);
        chk({tag, "_busy_after"}, {31'b0, busy_o}, 32'd0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    endtask

    function automatic vec_t mk(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                                input logic req, input logic [31:0] pc,
                                input logic ev, input logic ee, input logic [31:0] ei);
        vec_t v;
        v.we = we; v.waddr = wa; v.wdata = wd; v.req = req; v.pc = pc;
        v.ev = ev; v.ee = ee; v.ei = ei;
        return v;
    endfunction

    initial begin
        int      r;
        int      all_nop_bad;
        logic    e_valid;
        logic    e_err;
        logic [7:0] idx;

        vecs[0]  = mk(1, 8'd1, 32'h00F0_8093, 0, 32'h0,        0, 0, NOP);
        vecs[1]  = mk(1, 8'd3, 32'h0020_80B3, 0, 32'h0,        0, 0, NOP);
        vecs[2]  = mk(0, 8'd0, 32'h0,         1, 32'h4,        1, 0, 32'h00F0_8093);
        vecs[3]  = mk(0, 8'd0, 32'h0,         1, 32'hC,        1, 0, 32'h0020_80B3);
        vecs[4]  = mk(0, 8'd0, 32'h0,         1, 32'h6,        1, 1, NOP);
        vecs[5]  = mk(0, 8'd0, 32'h0,         1, 32'h400,      1, 1, NOP);
        vecs[6]  = mk(0, 8'd0, 32'h0,         0, 32'h0,        0, 0, NOP);
        vecs[7]  = mk(1, 8'd5, 32'hFE00_0EE3, 1, 32'h14,       1, 0, 32'hFE00_0EE3);
        vecs[8]  = mk(1, 8'd1, 32'h1111_1111, 1, 32'hC,        1, 0, 32'h0020_80B3);
        vecs[9]  = mk(0, 8'd0, 32'h0,         1, 32'h4,        1, 0, 32'h1111_1111);
        vecs[10] = mk(0, 8'd0, 32'h0,         1, 32'h3FC,      1, 0, NOP);
        vecs[11] = mk(0, 8'd0, 32'h0,         1, 32'h8000_0000, 1, 1, NOP);
        vecs[12] = mk(0, 8'd0, 32'h0,         1, 32'h3,        1, 1, NOP);
        vecs[13] = mk(0, 8'd0, 32'h0,         0, 32'h0,        0, 0, NOP);

        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_inst", inst_o, NOP);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_err", {31'b0, inst_err_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd1);
        chk("rst_ready", {31'b0, prog_ready_o}, 32'd0);

        rst = 1'b0;
        run_sweep("first");

        all_nop_bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            fetch_req_i = 1'b1;
            pc_i        = i * 4;
            step();
            if (inst_o !== NOP || inst_err_o !== 1'b0 || inst_valid_o !== 1'b1) begin
                all_nop_bad++;
                $display("FAIL sweep_fetch idx %0d: got inst=%h err=%b valid=%b expected inst=%h err=0 valid=1",
                         i, inst_o, inst_err_o, inst_valid_o, NOP);
            end
        end
        checks++;
        if (all_nop_bad != 0) failures++;
        idle_inputs();

        foreach (vecs[i]) begin
            prog_we_i   = vecs[i].we;
            prog_addr_i = vecs[i].waddr;
            prog_data_i = vecs[i].wdata;
            fetch_req_i = vecs[i].req;
            pc_i        = vecs[i].pc;
            step();
            if (vecs[i].we) model_mem[vecs[i].waddr] = vecs[i].wdata;
            chk($sformatf("vec%0d_inst", i), inst_o, vecs[i].ei);
            chk($sformatf("vec%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, vecs[i].ev});
            chk($sformatf("vec%0d_err", i), {31'b0, inst_err_o}, {31'b0, vecs[i].ee});
        end
        idle_inputs();
        exp_inst = NOP;

        for (int c = 0; c < 300; c++) begin
            prog_we_i   = ($urandom_range(0, 2) == 0);
            prog_addr_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            prog_data_i = $urandom;
            fetch_req_i = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 9);
            idx = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            if (r < 7)       pc_i = {22'b0, idx, 2'b00};
            else if (r == 7) pc_i = {22'b0, idx, 2'b00} + 32'($urandom_range(1, 3));
            else             pc_i = $urandom | 32'h0000_0400;

            e_valid = fetch_req_i;
            e_err   = 1'b0;
            if (fetch_req_i) begin
                if (pc_i % 4 != 0 || pc_i >= DEPTH * 4) begin
                    e_err    = 1'b1;
                    exp_inst = NOP;
                end else if (prog_we_i && prog_addr_i == pc_i / 4) begin
                    exp_inst = prog_data_i;
                end else begin
                    exp_inst = model_mem[pc_i / 4];
                end
            end
            if (prog_we_i) model_mem[prog_addr_i] = prog_data_i;
            step();
            chk($sformatf("rnd%0d_inst", c), inst_o, exp_inst);
            chk($sformatf("rnd%0d_valid", c), {31'b0, inst_valid_o}, {31'b0, e_valid});
            chk($sformatf("rnd%0d_err", c), {31'b0, inst_err_o}, {31'b0, e_err});
        end
        idle_inputs();

        prog_we_i   = 1'b1;
        prog_addr_i = 8'd1;
        prog_data_i = 32'hABCD_0001;
        fetch_req_i = 1'b1;
        pc_i        = 32'h4;
        step();
        chk("pre_rst_inst", inst_o, 32'hABCD_0001);
        prog_we_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_inst", inst_o, NOP);
        chk("async_rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("async_rst_busy", {31'b0, busy_o}, 32'd1);
        chk("async_rst_ready", {31'b0, prog_ready_o}, 32'd0);
        step();
        rst = 1'b0;
        idle_inputs();
        run_sweep("second");

        fetch_req_i = 1'b1;
        pc_i        = 32'h4;
        step();
        chk("post_sweep_idx1", inst_o, NOP);
        chk("post_sweep_valid", {31'b0, inst_valid_o}, 32'd1);
        pc_i = 32'h1C;
        step();
        chk("init_write_ignored_idx7", inst_o, NOP);
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_mem.md
# inst_mem

Parametrised, writable instruction memory that replaces the fixed case-table instruction ROM in front of the IF stage. Holds DEPTH words and fills itself with NOP after reset. It then accepts program words from a loader port and serves fetches with a registered one-cycle read and valid/error flags. Byte-addressed PCs are mapped to word indices, and misaligned or out-of-range fetches are flagged.

## Interface
- DATA_W, 32: instruction width in bits.
- ADDR_W, 32: PC width in bits, byte address.
- DEPTH, 256: words stored; must be a power of two, ≥ 2. IDX_W = log2(DEPTH).
- NOP, 32'h0000_0013: fill word and error return value (`addi x0,x0,0`).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- fetch_req_i  in  1  fetch request this cycle.
- pc_i  in  ADDR_W  byte address of the requested instruction.
- inst_o  out  DATA_W  fetched instruction, registered.
- inst_valid_o  out  1  inst_o holds the result of the previous cycle's accepted fetch.
- inst_err_o  out  1  previous accepted fetch was misaligned or out of range.
- prog_we_i  in  1  loader write strobe.
- prog_addr_i  in  IDX_W  loader word index.
- prog_data_i  in  DATA_W  loader write data.
- prog_ready_o  out  1  loader writes are accepted this cycle.
- busy_o  out  1  NOP fill sweep in progress.

## Operation
- FSM has two states: INIT and RUN. rst forces INIT, and this applies at any time, including mid-sweep or mid-fetch.
- INIT:
  - The fill counter starts at 0.
  - Each edge writes NOP to mem[counter], then increments the counter.
  - When the counter reaches DEPTH-1, that edge writes the last word and moves to RUN.
  - busy_o=1 and prog_ready_o=0. Fetch requests and prog_we_i are ignored, and inst_valid_o stays 0.
- RUN:
  - busy_o=0 and prog_ready_o=1. The FSM stays in RUN until rst.
- Fetch is accepted when the FSM is in RUN and fetch_req_i=1.
- Index = pc_i[IDX_W+1:2].
- Misaligned means pc_i[1:0]≠0. Out of range means any pc_i bit above IDX_W+1 is nonzero.
- On an accepted fetch, the next edge sets:
  - inst_valid_o=1.
  - If misaligned or out of range: inst_err_o=1 and inst_o=NOP.
  - Otherwise: inst_err_o=0 and inst_o=mem[index].
- Cycle with no accepted fetch: the next edge clears inst_valid_o and inst_err_o. inst_o holds its last value.
- Program write: in RUN with prog_we_i=1, the edge stores prog_data_i at mem[prog_addr_i]. Every write completes in one cycle; there is no backpressure in RUN.
- Simultaneous write and fetch to the same index are write-first: inst_o returns prog_data_i.
- Writes to other indices do not disturb the fetch.

## Timing
- Reset values, held while rst=1:
  - inst_o=NOP, inst_valid_o=0, inst_err_o=0.
  - busy_o=1, prog_ready_o=0.
  - FSM=INIT, fill counter=0.
- Fill sweep after rst deasserts:
  - Edge k (k=1..DEPTH) writes index k-1.
  - busy_o falls and prog_ready_o rises after edge DEPTH.
  - With default DEPTH the first loader write or fetch is accepted in cycle 257.
- Fetch latency is 1 cycle. A request sampled at edge N shows inst_o/inst_valid_o after edge N; back-to-back requests give one result per cycle.
- Write-to-read latency: data written at edge N can be read by a fetch sampled at edge N (bypass) or later.
- Reset asserted mid-stream drops outputs to reset values immediately (asynchronous). Memory contents after the next sweep are all NOP.

## Test plan
- Reset release, DEPTH=256 → busy_o=1 for exactly 256 edges, then busy_o=0 and prog_ready_o=1. Fetch of every index 0..255 returns 32'h0000_0013 with inst_err_o=0.
- Load 0x00F08093 at index 1 and 0x002080B3 at index 3. Fetch pc 0x4, then 0xC on consecutive cycles → inst_o=0x00F08093 and then 0x002080B3, each one cycle after the request, inst_valid_o=1 both cycles.
- Fetch pc=0x6 → inst_o=NOP, inst_err_o=1, inst_valid_o=1. Fetch pc=0x400 (out of range) → same response. Next cycle with fetch_req_i=0 → inst_valid_o=0, inst_err_o=0.
- Same cycle: prog_we_i=1, prog_addr_i=5, prog_data_i=0xFE000EE3, and fetch pc=0x14 → inst_o=0xFE000EE3 next cycle.
- prog_we_i and fetch_req_i pulsed during INIT → no memory change, inst_valid_o stays 0, sweep length unchanged.
- After loading data, assert rst for 1 cycle mid-fetch → outputs go to reset values immediately. A new 256-cycle sweep runs, and the previously loaded index 1 then reads NOP.
